// File: rtl/pingpong_pe_feeder.sv
// rtl/pingpong_pe_feeder.sv - ping-pong byte buffer feeding LANES-wide beats to the PE array
module pingpong_pe_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LANES  = 4,
    parameter int PE_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [DATA_W-1:0]         i_data_din,
    input  logic                      i_data_din_vld,
    output logic                      o_wr_ready,
    input  logic                      i_switch_pingpong,
    output logic [LANES*DATA_W-1:0]   o_data_dout,
    output logic                      o_data_dout_vld,
    input  logic                      i_dout_ready,
    output logic                      o_pe_tick,
    output logic                      o_wr_bank,
    output logic                      o_rd_busy,
    output logic                      o_overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = DEPTH / LANES;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = (PE_DIV > 1) ? $clog2(PE_DIV) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    logic [DATA_W-1:0]       mem [2][DEPTH];
    logic [CW-1:0]           wr_cnt;
    logic [CW-1:0]           rd_len;
    logic [CW-1:0]           sel_len;
    logic [CW-1:0]           len_at_switch;
    logic [CW:0]             sel_base;
    logic [CW:0]             widx;
    logic                    sel_bank;
    logic [BW-1:0]           beat_idx;
    logic [BW-1:0]           beat_idx_nxt;
    logic [TW-1:0]           tick_cnt;
    logic                    sw_pend;
    logic                    wr_bank;
    logic                    overflow;
    state_t                  state;
    state_t                  state_nxt;
    logic [LANES*DATA_W-1:0] dout_q;
    logic [LANES*DATA_W-1:0] dout_nxt;
    logic [LANES*DATA_W-1:0] beat_data;
    logic                    vld_q;
    logic                    vld_nxt;
    logic                    wr_en;
    logic                    sw_accept;
    logic                    xfer;
    logic                    last_beat;

    assign o_wr_ready    = en && (wr_cnt < CW'(DEPTH));
    assign wr_en         = i_data_din_vld && o_wr_ready;
    assign o_pe_tick     = en && (tick_cnt == TW'(PE_DIV - 1));
    assign sw_accept     = (sw_pend || i_switch_pingpong) && en && (state == IDLE);
    assign xfer          = vld_q && i_dout_ready && o_pe_tick;
    assign len_at_switch = wr_cnt + CW'(wr_en);
    assign last_beat     = ((int'(beat_idx) + 1) * LANES) >= int'(rd_len);

    assign o_data_dout     = dout_q;
    assign o_data_dout_vld = vld_q;
    assign o_rd_busy       = (state == STREAM);
    assign o_wr_bank       = wr_bank;
    assign o_overflow      = overflow;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_cnt[AW-1:0]] <= i_data_din;
        end
    end

    // In IDLE the beat source is the bank about to be handed over, so beat 0
    // can be loaded on the accept edge itself.
    always_comb begin
        if (state == IDLE) begin
            sel_bank = wr_bank;
            sel_base = '0;
            sel_len  = len_at_switch;
        end else begin
            sel_bank = ~wr_bank;
            sel_base = (CW+1)'((int'(beat_idx) + 1) * LANES);
            sel_len  = rd_len;
        end
    end

    // A word written on the accept cycle is not in mem yet; forward it.
    always_comb begin
        beat_data = '0;
        widx      = '0;
        for (int l = 0; l < LANES; l++) begin
            widx = sel_base + (CW+1)'(l);
            if (widx < {1'b0, sel_len}) begin
                if (wr_en && (sel_bank == wr_bank) && (widx == {1'b0, wr_cnt})) begin
                    beat_data[l*DATA_W +: DATA_W] = i_data_din;
                end else begin
                    beat_data[l*DATA_W +: DATA_W] = mem[sel_bank][widx[AW-1:0]];
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        dout_nxt     = dout_q;
        vld_nxt      = vld_q;
        case (state)
            IDLE: begin
                if (sw_accept && (sel_len != '0)) begin
                    state_nxt    = STREAM;
                    beat_idx_nxt = '0;
                    dout_nxt     = beat_data;
                    vld_nxt      = 1'b1;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (last_beat) begin
                        state_nxt    = IDLE;
                        beat_idx_nxt = '0;
                        dout_nxt     = '0;
                        vld_nxt      = 1'b0;
                    end else begin
                        beat_idx_nxt = beat_idx + 1'b1;
                        dout_nxt     = beat_data;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_idx <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_idx_nxt;
            dout_q   <= dout_nxt;
            vld_q    <= vld_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            rd_len   <= '0;
            tick_cnt <= '0;
            sw_pend  <= 1'b0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                tick_cnt <= (tick_cnt == TW'(PE_DIV - 1)) ? '0 : tick_cnt + 1'b1;
            end
            if (sw_accept) begin
                wr_bank <= ~wr_bank;
                rd_len  <= len_at_switch;
                wr_cnt  <= '0;
                sw_pend <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
                if (i_switch_pingpong) begin
                    sw_pend <= 1'b1;
                end
            end
            if (i_data_din_vld && en && (wr_cnt == CW'(DEPTH))) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pingpong_pe_feeder.sv
// tb/tb_pingpong_pe_feeder.sv - randomized self-checking bench for pingpong_pe_feeder
module tb_pingpong_pe_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LANES  = 4;
    localparam int PE_DIV = 2;
    localparam int BEAT_W = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [DATA_W-1:0] i_data_din;
    logic              i_data_din_vld;
    logic              o_wr_ready;
    logic              i_switch_pingpong;
    logic [BEAT_W-1:0] o_data_dout;
    logic              o_data_dout_vld;
    logic              i_dout_ready;
    logic              o_pe_tick;
    logic              o_wr_bank;
    logic              o_rd_busy;
    logic              o_overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [BEAT_W-1:0] got[$];
    logic [BEAT_W-1:0] exp_q[$];
    int                xfer_cyc[$];
    logic [DATA_W-1:0] wq[$];
    logic              m_bank;
    logic              m_ovf;

    pingpong_pe_feeder #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .PE_DIV(PE_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i_data_din(i_data_din), .i_data_din_vld(i_data_din_vld), .o_wr_ready(o_wr_ready),
        .i_switch_pingpong(i_switch_pingpong),
        .o_data_dout(o_data_dout), .o_data_dout_vld(o_data_dout_vld), .i_dout_ready(i_dout_ready),
        .o_pe_tick(o_pe_tick), .o_wr_bank(o_wr_bank), .o_rd_busy(o_rd_busy), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_data_dout_vld && i_dout_ready && o_pe_tick) begin
            got.push_back(o_data_dout);
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got.delete();
        exp_q.delete();
        xfer_cyc.delete();
    endtask

    // Reference: the write bank is a list of words; a switch slices it into LANES-word beats.
    function automatic void model_switch();
        logic [BEAT_W-1:0] b;
        int n;
        n = wq.size();
        for (int k = 0; k * LANES < n; k++) begin
            b = '0;
            for (int l = 0; l < LANES; l++) begin
                if (k * LANES + l < n) b[l*DATA_W +: DATA_W] = wq[k*LANES + l];
            end
            exp_q.push_back(b);
        end
        wq.delete();
        m_bank = ~m_bank;
    endfunction

    task automatic write_word(input logic [DATA_W-1:0] d, input bit sw);
        i_data_din        = d;
        i_data_din_vld    = 1'b1;
        i_switch_pingpong = sw;
        if (wq.size() < DEPTH) wq.push_back(d);
        else m_ovf = 1'b1;
        if (sw) model_switch();
        step();
        i_data_din_vld    = 1'b0;
        i_switch_pingpong = 1'b0;
    endtask

    task automatic pulse_switch();
        i_switch_pingpong = 1'b1;
        step();
        i_switch_pingpong = 1'b0;
    endtask

    task automatic wait_got(input int n, output bit ok);
        int b;
        b = 0;
        while (got.size() < n && b < 400) begin
            step();
            b++;
        end
        ok = (got.size() >= n);
    endtask

    task automatic drain(input bit rnd, output bit ok);
        int b;
        b = 0;
        while (o_rd_busy && b < 600) begin
            if (rnd) i_dout_ready = 1'($urandom_range(0, 1));
            step();
            b++;
        end
        i_dout_ready = 1'b1;
        ok = !o_rd_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; i_data_din = '0; i_data_din_vld = 1'b0;
        i_switch_pingpong = 1'b0; i_dout_ready = 1'b1;
        m_bank = 1'b0; m_ovf = 1'b0;
        step(); step();
        checks++;
        if ({o_wr_bank, o_data_dout_vld, o_rd_busy, o_overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {o_wr_bank, o_data_dout_vld, o_rd_busy, o_overflow});
        end
        checks++;
        if (o_data_dout !== '0) begin
            errors++; $display("FAIL reset_dout got %h exp 0", o_data_dout);
        end
        checks++;
        if ({o_pe_tick, o_wr_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_en0 tick/ready got %b exp 00", {o_pe_tick, o_wr_ready});
        end
        en = 1'b1;
        #1;
        checks++;
        if (o_wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_en1 wr_ready got %b exp 1", o_wr_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_stream();
        bit ok;
        clear_obs();
        for (int i = 0; i < 16; i++) write_word(8'(i), 1'b0);
        model_switch();
        pulse_switch();
        checks++;
        if ({o_data_dout_vld, o_rd_busy, o_wr_bank} !== {2'b11, m_bank} || o_data_dout !== exp_q[0]) begin
            errors++;
            $display("FAIL basic_first_beat got vld/busy/bank %b dout %h exp %b %h",
                     {o_data_dout_vld, o_rd_busy, o_wr_bank}, o_data_dout, {2'b11, m_bank}, exp_q[0]);
        end
        drain(1'b0, ok);
        checks++;
        if (!ok || got.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_count got %0d beats exp %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++; $display("FAIL basic_beat%0d got %h exp %h", i, got[i], exp_q[i]);
                end
            end
        end
        for (int i = 1; i < xfer_cyc.size(); i++) begin
            checks++;
            if (xfer_cyc[i] - xfer_cyc[i-1] != PE_DIV) begin
                errors++; $display("FAIL basic_interval%0d got %0d exp %0d", i, xfer_cyc[i] - xfer_cyc[i-1], PE_DIV);
            end
        end
        checks++;
        if (o_data_dout_vld !== 1'b0 || o_data_dout !== '0) begin
            errors++; $display("FAIL basic_after_last got vld %b dout %h exp 0 0", o_data_dout_vld, o_data_dout);
        end
    endtask

    task automatic test_partial_bank();
        bit ok;
        clear_obs();
        for (int i = 0; i < 6; i++) write_word(8'(8'hA0 + i), 1'b0);
        model_switch();
        pulse_switch();
        drain(1'b0, ok);
        checks++;
        if (!ok || got.size() != 2) begin
            errors++; $display("FAIL partial_count got %0d beats exp 2", got.size());
        end
        foreach (exp_q[i]) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++; $display("FAIL partial_beat%0d got %h exp %h", i, got[i], exp_q[i]);
                end
            end
        end
        if (got.size() == 2) begin
            checks++;
            if (got[1] !== 32'h0000A5A4) begin
                errors++; $display("FAIL partial_zero_lanes got %h exp 0000a5a4", got[1]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_obs();
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (o_wr_ready !== (wq.size() < DEPTH)) begin
                errors++; $display("FAIL ovf_wr_ready word%0d got %b exp %b", i, o_wr_ready, wq.size() < DEPTH);
            end
            write_word(8'($urandom), 1'b0);
        end
        checks++;
        if (o_overflow !== m_ovf) begin
            errors++; $display("FAIL ovf_flag got %b exp %b", o_overflow, m_ovf);
        end
        model_switch();
        pulse_switch();
        drain(1'b0, ok);
        checks++;
        if (!ok || got.size() != exp_q.size()) begin
            errors++; $display("FAIL ovf_count got %0d beats exp %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++; $display("FAIL ovf_beat%0d got %h exp %h", i, got[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got %b exp 1", o_overflow);
        end
    endtask

    task automatic test_pingpong_pending();
        bit ok;
        logic b1;
        clear_obs();
        for (int i = 0; i < 16; i++) write_word(8'($urandom), 1'b0);
        model_switch();
        b1 = m_bank;
        pulse_switch();
        wait_got(1, ok);
        i_dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(8'($urandom), 1'b0);
        model_switch();
        pulse_switch();
        checks++;
        if (o_rd_busy !== 1'b1 || o_wr_bank !== b1) begin
            errors++; $display("FAIL pend_held got busy %b bank %b exp 1 %b", o_rd_busy, o_wr_bank, b1);
        end
        i_dout_ready = 1'b1;
        wait_got(4, ok);
        checks++;
        if (!ok || o_rd_busy !== 1'b0 || o_data_dout_vld !== 1'b0) begin
            errors++; $display("FAIL pend_gap got busy %b vld %b exp 0 0", o_rd_busy, o_data_dout_vld);
        end
        step();
        checks++;
        if (o_rd_busy !== 1'b1 || o_wr_bank !== m_bank || o_data_dout !== exp_q[4]) begin
            errors++;
            $display("FAIL pend_swap got busy %b bank %b dout %h exp 1 %b %h",
                     o_rd_busy, o_wr_bank, o_data_dout, m_bank, exp_q[4]);
        end
        drain(1'b0, ok);
        checks++;
        if (!ok || got.size() != exp_q.size()) begin
            errors++; $display("FAIL pend_count got %0d beats exp %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++; $display("FAIL pend_beat%0d got %h exp %h", i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_pressure_enable();
        bit ok;
        logic [BEAT_W-1:0] d;
        logic p;
        clear_obs();
        for (int i = 0; i < 16; i++) write_word(8'($urandom), 1'b0);
        model_switch();
        pulse_switch();
        wait_got(1, ok);
        i_dout_ready = 1'b0;
        d = o_data_dout;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (o_data_dout !== d || o_data_dout_vld !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d got %h vld %b exp %h 1", i, o_data_dout, o_data_dout_vld, d);
            end
        end
        p = o_pe_tick;
        en = 1'b0;
        i_dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_data_dout !== d || o_pe_tick !== 1'b0) begin
                errors++; $display("FAIL en_hold%0d got %h tick %b exp %h 0", i, o_data_dout, o_pe_tick, d);
            end
        end
        checks++;
        if (got.size() != 1) begin
            errors++; $display("FAIL en_no_xfer got %0d beats exp 1", got.size());
        end
        en = 1'b1;
        #1;
        checks++;
        if (o_pe_tick !== p) begin
            errors++; $display("FAIL en_tick_frozen got %b exp %b", o_pe_tick, p);
        end
        drain(1'b0, ok);
        checks++;
        if (!ok || got.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count got %0d beats exp %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random_rounds();
        bit ok;
        bit sw_last;
        int n;
        for (int r = 0; r < 8; r++) begin
            clear_obs();
            n = $urandom_range(0, DEPTH);
            sw_last = (n > 0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) write_word(8'($urandom), sw_last && (i == n - 1));
            if (!sw_last) begin
                model_switch();
                pulse_switch();
            end
            drain(1'b1, ok);
            checks++;
            if (!ok || got.size() != exp_q.size() || o_wr_bank !== m_bank) begin
                errors++;
                $display("FAIL rand%0d_count got %0d beats bank %b exp %0d %b", r, got.size(), o_wr_bank, exp_q.size(), m_bank);
            end
            foreach (exp_q[i]) begin
                if (i < got.size()) begin
                    checks++;
                    if (got[i] !== exp_q[i]) begin
                        errors++; $display("FAIL rand%0d_beat%0d got %h exp %h", r, i, got[i], exp_q[i]);
                    end
                end
            end
            for (int i = 1; i < xfer_cyc.size(); i++) begin
                checks++;
                if (xfer_cyc[i] - xfer_cyc[i-1] < PE_DIV) begin
                    errors++; $display("FAIL rand%0d_interval got %0d exp >= %0d", r, xfer_cyc[i] - xfer_cyc[i-1], PE_DIV);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit seen;
        clear_obs();
        for (int i = 0; i < 16; i++) write_word(8'($urandom), 1'b0);
        model_switch();
        pulse_switch();
        wait_got(1, ok);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_wr_bank, o_data_dout_vld, o_rd_busy, o_overflow, o_wr_ready} !== 5'b00001 || o_data_dout !== '0) begin
            errors++;
            $display("FAIL arst_outputs got %b dout %h exp 00001 0",
                     {o_wr_bank, o_data_dout_vld, o_rd_busy, o_overflow, o_wr_ready}, o_data_dout);
        end
        #1;
        rst_n = 1'b1;
        wq.delete();
        m_bank = 1'b0;
        m_ovf = 1'b0;
        clear_obs();
        step();
        model_switch();
        pulse_switch();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_rd_busy || o_data_dout_vld) seen = 1'b1;
            step();
        end
        checks++;
        if (seen || got.size() != 0 || o_wr_bank !== m_bank) begin
            errors++;
            $display("FAIL arst_empty_switch got busy_seen %b beats %0d bank %b exp 0 0 %b", seen, got.size(), o_wr_bank, m_bank);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_partial_bank();
        test_overflow();
        test_pingpong_pending();
        test_back_pressure_enable();
        test_random_rounds();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
